// File: rtl/seven_seg_pkg.sv
// Shared constants, segment table and scan state type for the seven-segment scanner.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK    = 7'h7F;
  localparam logic [7:0] ANODE_OFF    = 8'hFF;
  localparam logic [7:0] ANODE_DIGIT0 = 8'h80;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Active-low gfedcba codes, entry 15 (F) leftmost down to entry 0 rightmost
  localparam logic [15:0][6:0] HEX_SEG_LUT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] hex_seg_lookup(input logic [3:0] nib);
    return HEX_SEG_LUT[nib];
  endfunction

  // Digit i pulls anode bit (7-i) low
  function automatic logic [7:0] digit_anode(input logic [2:0] idx);
    return ~(ANODE_DIGIT0 >> idx);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment code.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Table lookup
  always_comb begin
    seg_o = hex_seg_lookup(hex_i);
  end

endmodule

// File: rtl/seven_seg_scanner_chk.sv
// Property checker for the scanner outputs: legal anode patterns and frame pulse alignment.
module seven_seg_scanner_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [7:0] anode,
  input logic [2:0] digit_idx,
  input logic       frame_done
);

  anode_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
    (anode == 8'hFF) || $onehot(~anode))
    else $error("anode pattern illegal: %h", anode);

  frame_done_idx_a: assert property (@(posedge clk) disable iff (!rst_n)
    frame_done |-> (digit_idx == 3'd0))
    else $error("frame_done with digit_idx=%0d", digit_idx);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 8-digit common-anode scanner with per-slot blanking gap and
// tear-free frame-boundary update of the displayed value.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  input  logic        load,
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  scan_state_t      state_q, state_d;
  logic             frame_done_q, frame_done_d;

  logic [31:0] act_val_q, act_val_d;
  logic [7:0]  act_dp_q, act_dp_d;
  logic [7:0]  act_en_q, act_en_d;
  logic [31:0] pend_val_q, pend_val_d;
  logic [7:0]  pend_dp_q, pend_dp_d;
  logic [7:0]  pend_en_q, pend_en_d;
  logic        pend_valid_q, pend_valid_d;

  logic [7:0]  anode_q, anode_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        slot_end_s;
  logic        wrap_s;
  logic [3:0]  nib_s;
  logic [6:0]  seg_code_s;

  assign slot_end_s = (cnt_q == CNT_LAST);
  assign wrap_s     = slot_end_s && (idx_q == 3'd7);

  // Slot counter, digit index and frame pulse
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    if (slot_end_s) begin
      cnt_d        = '0;
      idx_d        = idx_q + 3'd1;
      frame_done_d = wrap_s;
    end else begin
      cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // BLANK/DRIVE next state within a slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   state_d = (cnt_q == CNT_BLANK_LAST) ? DRIVE : BLANK;
      DRIVE:   state_d = slot_end_s ? BLANK : DRIVE;
      default: state_d = BLANK;
    endcase
  end

  // Pending capture on load; pending moves to active only at the frame wrap
  always_comb begin
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_valid_d = pend_valid_q;
    if (wrap_s && pend_valid_q) begin
      act_val_d    = pend_val_q;
      act_dp_d     = pend_dp_q;
      act_en_d     = pend_en_q;
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
    // A load in the wrap cycle lands in pending and waits for the next wrap
    if (load) begin
      pend_val_d   = value_in;
      pend_dp_d    = dp_in;
      pend_en_d    = digit_en;
      pend_valid_d = 1'b1;
    end else begin
      pend_val_d   = pend_val_q;
    end
  end

  // Nibble for the current digit: digit 0 sits in [31:28]
  assign nib_s = act_val_q[{~idx_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .hex_i (nib_s),
    .seg_o (seg_code_s)
  );

  // Output pattern for the next cycle
  always_comb begin
    anode_d = ANODE_OFF;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    if ((state_q == DRIVE) && act_en_q[~idx_q]) begin
      anode_d = digit_anode(idx_q);
      seg_d   = seg_code_s;
      dp_d    = ~act_dp_q[~idx_q];
    end else begin
      anode_d = ANODE_OFF;
    end
  end

  // Scan timing registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      state_q      <= BLANK;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Active and pending display data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_val_q    <= 32'h0000_0000;
      act_dp_q     <= 8'h00;
      act_en_q     <= 8'h00;
      pend_val_q   <= 32'h0000_0000;
      pend_dp_q    <= 8'h00;
      pend_en_q    <= 8'h00;
      pend_valid_q <= 1'b0;
    end else begin
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_q <= ANODE_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign anode      = anode_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for the 8-digit common-anode seven-segment display on the UART TX controller board. It takes a 32-bit hex value plus per-digit enable and decimal-point masks, then scans the digits one at a time. For each digit it drives an active-low one-hot anode pattern and the active-low segment code. A blanking gap separates consecutive digits to suppress ghosting. It is the producing end of the anode bus that `anode_decoder` consumes, and digit index ↔ anode bit mapping matches that decoder exactly.

## Interface
- `DIGIT_CYCLES`, default 100_000: clock cycles per digit slot (1 ms at 100 MHz).
- `BLANK_CYCLES`, default 1_000: leading cycles of each slot with all anodes off. Must satisfy 1 ≤ `BLANK_CYCLES` < `DIGIT_CYCLES`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `value_in`  in  32  hex value; nibble `[31:28]` is digit 0 (leftmost).
- `dp_in`  in  8  decimal-point mask; bit 7 is digit 0, 1 = lit.
- `digit_en`  in  8  digit enable mask; bit 7 is digit 0, 1 = digit shown.
- `load`  in  1  single-cycle strobe; captures `value_in`, `dp_in` and `digit_en` into the pending registers.
- `anode`  out  8  active-low one-hot; digit i drives bit (7−i) low.
- `seg`  out  7  active-low segments, bit order gfedcba (`seg[0]` = a).
- `dp`  out  1  active-low decimal point.
- `digit_idx`  out  3  index of the current slot, 0..7.
- `frame_done`  out  1  one-cycle pulse when slot 7 completes.

## Operation
- **Slot counter** `cnt` runs 0..`DIGIT_CYCLES`−1.
  - On terminal count: `cnt` returns to 0 and `digit_idx` increments, wrapping 7→0.
  - `frame_done` pulses on the 7→0 wrap.
- **Two-state FSM per slot:**
  - BLANK while `cnt` < `BLANK_CYCLES`.
  - DRIVE for the remainder of the slot.
  - Transitions are BLANK→DRIVE at `cnt` = `BLANK_CYCLES`, and DRIVE→BLANK at slot end.
- **In BLANK:** `anode` = 8'hFF, `seg` = 7'h7F, `dp` = 1.
- **In DRIVE with the digit enabled in the active mask:**
  - `anode` = ~(8'h80 >> `digit_idx`).
  - `seg` = hex code of the active nibble.
  - `dp` = ~active `dp` bit.
- **In DRIVE with the digit disabled:** same outputs as BLANK. Slot timing is unchanged.
- **Hex codes (active-low gfedcba):**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- **Tear-free update:**
  - `load` writes the pending registers and sets `pend_valid`.
  - Pending is copied to the active registers only on the cycle the 7→0 wrap occurs.
  - The new frame therefore starts with the new data from digit 0.
  - A second `load` before the wrap overwrites pending; last write wins.
  - `load` in the same cycle as the wrap: the captured data is applied at the *next* wrap. The current wrap applies whatever pending held before.

## Timing
- **Reset values (asynchronous, taking effect immediately):**
  - `anode` = 8'hFF, `seg` = 7'h7F, `dp` = 1.
  - `digit_idx` = 0, `frame_done` = 0, `cnt` = 0, FSM = BLANK.
  - Active and pending registers = 0; `pend_valid` = 0. The display stays dark until the first `load` + wrap.
- **Registered outputs:** `anode`, `seg` and `dp` lag the FSM/counter by exactly one cycle.
- **Per-slot waveform:** each slot shows exactly `BLANK_CYCLES` cycles with `anode` = FF, then exactly `DIGIT_CYCLES`−`BLANK_CYCLES` cycles driven.
- **Frame period:** 8×`DIGIT_CYCLES`, with no jitter.
- **Anode guarantee:** never more than one anode bit low in any cycle. `anode` is never a non-one-hot, non-FF value.
- **`frame_done`:** high for exactly one cycle, coincident with `digit_idx` showing 0 after the wrap.

## Structure
- `seven_seg_pkg` holds:
  - `SEG_BLANK` = 7'h7F and `ANODE_OFF` = 8'hFF.
  - The 16-entry hex→segment constant table.
  - The `scan_state_t` enum {BLANK, DRIVE}.
- One combinational sub-module, `hex_to_seg` (4-bit in, 7-bit out), which the verification bench also uses as a reference model.
- Counter width is `$clog2(DIGIT_CYCLES)`.

## Test plan
All directed tests use `DIGIT_CYCLES` = 16 and `BLANK_CYCLES` = 2.
- **Reset idle:** assert `rst_n` = 0 → outputs take their reset values immediately; with no `load`, `anode` stays FF for 3 full frames.
- **Basic scan:** `load` 32'h0123_4567, `digit_en` = FF, `dp_in` = 00.
  - Next frame: slot 0 drives `anode` = 0111_1111 with `seg` = 1000000; slot 7 drives `anode` = 1111_1110 with `seg` = 1111000.
  - Each slot shows 2 blank cycles and 14 driven cycles.
- **Round-trip:** feed `anode` into `anode_decoder` → on every driven cycle its `anode_sel` equals `digit_idx` delayed by one cycle.
- **Masks:** `digit_en` = 1000_0001, `dp_in` = 0000_0001 → only digits 0 and 7 light, only digit 7 has `dp` = 0, and `frame_done` period is still 128 cycles.
- **Mid-frame load:** `load` 32'hFFFF_FFFF during slot 3 → slots 3–7 keep the old data; from the next frame every slot shows `seg` = 0001110. Repeat with `load` coincident with the wrap → the update lands one frame later.
- **Reset mid-drive:** drop `rst_n` during slot 5 DRIVE → `anode` = FF in the same cycle, and after release scanning restarts at digit 0 with the display dark.
